// File: rtl/lock_pkg.sv
// Shared types and constants for the six-digit lock sequencer.
package lock_pkg;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CODE_W  = DIGITS * DIGIT_W;

  // State encodings, kept as plain constants so external debug tools can decode `state`.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_SET     = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_OPEN    = ST_OPEN,
    S_SET     = ST_SET,
    S_FAIL    = ST_FAIL,
    S_LOCKOUT = ST_LOCKOUT
  } lock_state_t;

  typedef logic [CODE_W-1:0] code_t;

  // Keypad values above 9 are non-digit keys and never enter the buffer.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] v);
    return (v <= DIGIT_W'(9));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digit_entry_buf.sv
// Digit entry buffer: shifts digits in from the right, counts them, stops at DIGITS.
module digit_entry_buf
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               push,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] digit,
  output code_t              code,
  output logic [2:0]         dcnt,
  output logic               full
);

  code_t      code_q;
  logic [2:0] cnt_q;

  assign full = (cnt_q == 3'(DIGITS));
  assign code = code_q;
  assign dcnt = cnt_q;

  // Clear wins over push; a push while full is dropped so the code never wraps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else if (push && !full) begin
      code_q <= {code_q[CODE_W-DIGIT_W-1:0], digit};
      cnt_q  <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Lock sequencer FSM: code compare, unlock window, password change and lockout.
// Optional feature macro: LOCKOUT_EN (failure counter, LOCKOUT state and alarm).
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned OPEN_CYC = 8,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              key_vld,
  input  logic [3:0]        key_val,
  input  logic              key_ent,
  input  logic              key_set,
  input  logic              key_cnl,
  input  logic [CODE_W-1:0] pw_cur,
  output logic              pw_we,
  output logic [CODE_W-1:0] pw_data,
  output logic [CODE_W-1:0] disp,
  output logic [2:0]        dcnt,
  output logic              unlock,
  output logic              err,
  output logic              alarm,
  output logic [2:0]        state
);

`ifdef LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int unsigned TIMER_MAX = LOCK_EN ? max_u(OPEN_CYC, LOCK_CYC) : OPEN_CYC;
  localparam int unsigned TW        = $clog2(TIMER_MAX + 1);

  lock_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlock_q, err_q, pw_we_q;
  code_t         pw_data_q;
  logic          buf_push, buf_clear, buf_full, do_write, fail_hit;
  code_t         buf_code;

  digit_entry_buf u_buf (
    .clk   (clk),
    .clr   (clr),
    .push  (buf_push),
    .clear (buf_clear),
    .digit (key_val),
    .code  (buf_code),
    .dcnt  (dcnt),
    .full  (buf_full)
  );

  // Next state, timer reload and buffer control; strobe priority cnl > ent > set > vld.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    buf_push  = 1'b0;
    buf_clear = 1'b0;
    do_write  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_cnl) begin
          buf_clear = 1'b1;
        end else if (key_ent) begin
          if (buf_full) state_d = (buf_code == pw_cur) ? S_OPEN : S_FAIL;
        end else if (!key_set && key_vld) begin
          buf_push = is_digit(key_val);
        end
      end
      S_OPEN: begin
        if (key_cnl) begin
          state_d = S_IDLE;
        end else if (key_set && !key_ent) begin
          state_d = S_SET;
        end else if (timer_q == TW'(1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SET: begin
        if (key_cnl) begin
          state_d = S_IDLE;
        end else if (key_ent) begin
          if (buf_full) begin
            do_write = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (!key_set && key_vld) begin
          buf_push = is_digit(key_val);
        end
      end
      S_FAIL: state_d = fail_hit ? S_LOCKOUT : S_IDLE;
`ifdef LOCKOUT_EN
      S_LOCKOUT: begin
        // Keys, including cancel, are deliberately not looked at here.
        if (timer_q == TW'(1)) state_d = S_IDLE;
        else timer_d = timer_q - TW'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Every transition empties the buffer and reloads the timer for the new state.
    if (state_d != state_q) begin
      buf_clear = 1'b1;
      buf_push  = 1'b0;
      unique case (state_d)
        S_OPEN:    timer_d = TW'(OPEN_CYC);
`ifdef LOCKOUT_EN
        S_LOCKOUT: timer_d = TW'(LOCK_CYC);
`endif
        default:   timer_d = '0;
      endcase
    end
  end

  // State, timer and registered outputs derived from the upcoming state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      unlock_q  <= 1'b0;
      err_q     <= 1'b0;
      pw_we_q   <= 1'b0;
      pw_data_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      unlock_q  <= (state_d == S_OPEN);
      err_q     <= (state_d == S_FAIL);
      pw_we_q   <= do_write;
      pw_data_q <= do_write ? buf_code : '0;
    end
  end

`ifdef LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  logic [FAIL_W-1:0] fail_q;
  logic              fail_inc, fail_clr, alarm_q;

  assign fail_inc = (state_q == S_IDLE) && (state_d == S_FAIL);
  assign fail_clr = ((state_q == S_IDLE) && (state_d == S_OPEN)) ||
                    ((state_q == S_LOCKOUT) && (state_d == S_IDLE));
  // Counter already holds the new count while in FAIL, so FAIL compares it directly.
  assign fail_hit = (fail_q == FAIL_W'(MAX_FAIL));

  // Saturating count of consecutive wrong codes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fail_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= (state_d == S_LOCKOUT);
      if (fail_clr) fail_q <= '0;
      else if (fail_inc && !fail_hit) fail_q <= fail_q + FAIL_W'(1);
    end
  end

  assign alarm = alarm_q;
`else
  assign fail_hit = 1'b0;
  assign alarm    = 1'b0;
`endif

  assign state   = state_q;
  assign unlock  = unlock_q;
  assign err     = err_q;
  assign pw_we   = pw_we_q;
  assign pw_data = pw_data_q;
  assign disp    = buf_code;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: queue-based behavioural model plus literal checks.
module tb_lock_sequencer;
  import lock_pkg::*;

  localparam int OPEN_CYC = 8;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 16;
`ifdef LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        key_vld = 1'b0, key_ent = 1'b0, key_set = 1'b0, key_cnl = 1'b0;
  logic [3:0]  key_val = 4'd0;
  logic [23:0] pw_cur = 24'h123456;
  logic        pw_we, unlock, err, alarm;
  logic [23:0] pw_data, disp;
  logic [2:0]  dcnt, state;

  always #5 clk = ~clk;

  lock_sequencer #(.OPEN_CYC(OPEN_CYC), .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC)) dut (
    .clk     (clk),
    .clr     (clr),
    .key_vld (key_vld),
    .key_val (key_val),
    .key_ent (key_ent),
    .key_set (key_set),
    .key_cnl (key_cnl),
    .pw_cur  (pw_cur),
    .pw_we   (pw_we),
    .pw_data (pw_data),
    .disp    (disp),
    .dcnt    (dcnt),
    .unlock  (unlock),
    .err     (err),
    .alarm   (alarm),
    .state   (state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_OPEN = 1, M_SET = 2, M_FAIL = 3, M_LOCK = 4;
  int          m_mode = M_IDLE;
  int          m_left = 0;
  int          m_fails = 0;
  int          m_q[$];
  bit          m_we = 1'b0;
  logic [23:0] m_data = '0;

  function automatic logic [23:0] m_code();
    logic [23:0] c = '0;
    foreach (m_q[i]) c = {c[19:0], 4'(m_q[i])};
    return c;
  endfunction

  function automatic logic [2:0] m_state_enc();
    case (m_mode)
      M_OPEN:  return S_OPEN;
      M_SET:   return S_SET;
      M_FAIL:  return S_FAIL;
      M_LOCK:  return S_LOCKOUT;
      default: return S_IDLE;
    endcase
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (clr) begin
      m_mode = M_IDLE; m_left = 0; m_fails = 0; m_q.delete(); m_we = 0; m_data = '0;
    end else begin
      nxt = m_mode; m_we = 0; m_data = '0;
      case (m_mode)
        M_IDLE: begin
          if (key_cnl) m_q.delete();
          else if (key_ent) begin
            if (m_q.size() == 6) begin
              if (m_code() == pw_cur) begin
                nxt = M_OPEN; m_fails = 0;
              end else begin
                nxt = M_FAIL;
                if (m_fails < MAX_FAIL) m_fails++;
              end
            end
          end else if (!key_set && key_vld && key_val <= 9 && m_q.size() < 6)
            m_q.push_back(int'(key_val));
        end
        M_OPEN: begin
          if (key_cnl) nxt = M_IDLE;
          else if (key_set && !key_ent) nxt = M_SET;
          else begin
            m_left--;
            if (m_left == 0) nxt = M_IDLE;
          end
        end
        M_SET: begin
          if (key_cnl) nxt = M_IDLE;
          else if (key_ent) begin
            if (m_q.size() == 6) begin
              m_we = 1; m_data = m_code(); nxt = M_IDLE;
            end
          end else if (!key_set && key_vld && key_val <= 9 && m_q.size() < 6)
            m_q.push_back(int'(key_val));
        end
        M_FAIL: nxt = (LOCK_EN && m_fails == MAX_FAIL) ? M_LOCK : M_IDLE;
        default: begin
          m_left--;
          if (m_left == 0) begin
            nxt = M_IDLE; m_fails = 0;
          end
        end
      endcase
      if (nxt != m_mode) begin
        m_q.delete();
        if (nxt == M_OPEN) m_left = OPEN_CYC;
        else if (nxt == M_LOCK) m_left = LOCK_CYC;
      end
      m_mode = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  int          unlock_cnt = 0, err_cnt = 0, alarm_cnt = 0, we_cnt = 0;
  logic [23:0] we_data = '0;

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state_enc()));
    chk("disp", 32'(disp), 32'(m_code()));
    chk("dcnt", 32'(dcnt), 32'(m_q.size()));
    chk("unlock", 32'(unlock), 32'(m_mode == M_OPEN));
    chk("err", 32'(err), 32'(m_mode == M_FAIL));
    chk("alarm", 32'(alarm), 32'(m_mode == M_LOCK));
    chk("pw_we", 32'(pw_we), 32'(m_we));
    chk("pw_data", 32'(pw_data), 32'(m_data));
    if (unlock) unlock_cnt++;
    if (err) err_cnt++;
    if (alarm) alarm_cnt++;
    if (pw_we) begin
      we_cnt++;
      we_data = pw_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic vld, input logic [3:0] val, input logic ent,
                      input logic set, input logic cnl);
    @(negedge clk);
    #1;
    key_vld = vld; key_val = val; key_ent = ent; key_set = set; key_cnl = cnl;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic keys(input logic [23:0] c);
    for (int i = 0; i < 6; i++) step(1'b1, c[23-4*i -: 4], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input logic [23:0] c);
    keys(c);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic pulse_clr();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    idle(2);
    clr = 1'b0;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_disp", 32'(disp), 32'h0);
    chk("rst_dcnt", 32'(dcnt), 32'h0);

    // Correct code: unlock window then back to idle.
    unlock_cnt = 0;
    enter_code(24'h123456);
    idle(10);
    chk("open_cycles", 32'(unlock_cnt), 32'd8);
    chk("open_dcnt_after", 32'(dcnt), 32'd0);

    // Partial entry, then overflow digit ignored.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("partial_dcnt", 32'(dcnt), 32'd3);
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hb, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("full_disp", 32'(disp), 32'h123456);
    chk("full_dcnt", 32'(dcnt), 32'd6);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("cnl_dcnt", 32'(dcnt), 32'd0);

    // Three wrong codes, then keys during the lockout window.
    err_cnt = 0;
    alarm_cnt = 0;
    repeat (3) enter_code(24'h000000);
    enter_code(24'h123456);
    idle(20);
    chk("wrong_errs", 32'(err_cnt), 32'd3);
    chk("lock_alarm", 32'(alarm_cnt), LOCK_EN ? 32'd16 : 32'd0);

    // Password change.
    we_cnt = 0;
    enter_code(24'h123456);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    keys(24'h987654);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("set_we_count", 32'(we_cnt), 32'd1);
    chk("set_we_data", 32'(we_data), 32'h987654);
    idle(8);

    // Abort SET with clr, then with key_cnl.
    for (int k = 0; k < 2; k++) begin
      we_cnt = 0;
      enter_code(24'h123456);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      if (k == 0) pulse_clr();
      else step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle(2);
      chk("abort_state", 32'(state), 32'(ST_IDLE));
      chk("abort_dcnt", 32'(dcnt), 32'd0);
      chk("abort_unlock", 32'(unlock), 32'd0);
      chk("abort_we", 32'(we_cnt), 32'd0);
    end

    // Cancel beats enter on a correct full code.
    unlock_cnt = 0;
    keys(24'h123456);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle(12);
    chk("cnl_ent_unlock", 32'(unlock_cnt), 32'd0);
    chk("cnl_ent_dcnt", 32'(dcnt), 32'd0);

`ifndef LOCKOUT_EN
    // Without lockout, repeated failures never raise the alarm.
    err_cnt = 0;
    alarm_cnt = 0;
    repeat (5) enter_code(24'h000000);
    idle(4);
    chk("nolock_errs", 32'(err_cnt), 32'd5);
    chk("nolock_alarm", 32'(alarm_cnt), 32'd0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Sequencing controller for the six-digit electronic lock. It collects keypad digits into an entry buffer and compares the completed code against the stored password. It drives the unlock and alarm indications and owns the password-change sequence, issuing write requests to the password register. It sits between the keypad front end and the existing password register and judge datapath, replacing free-running mode and judge strobes with an explicit state machine.

## Interface
Parameters:
- OPEN_CYC, 8: cycles `unlock` stays high after a correct code (≥1).
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout (≥1).
- LOCK_CYC, 16: lockout duration in cycles (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  asynchronous, active-high reset.
- key_vld  in  1  one-cycle strobe: `key_val` is a keypress.
- key_val  in  4  digit value; values > 9 are ignored.
- key_ent  in  1  enter strobe.
- key_set  in  1  request password change (honoured only in OPEN).
- key_cnl  in  1  cancel: clear buffer and abort SET.
- pw_cur  in  24  stored password, digit 1 in [23:20] … digit 6 in [3:0].
- pw_we  out  1  one-cycle write strobe to the password register.
- pw_data  out  24  new password, valid when `pw_we`=1.
- disp  out  24  entry buffer contents, same digit order as `pw_cur`.
- dcnt  out  3  digits entered, 0..6.
- unlock  out  1  high while in OPEN.
- err  out  1  one-cycle pulse on a wrong code.
- alarm  out  1  high while in LOCKOUT.
- state  out  3  current state encoding, for debug.

## Operation
- States: IDLE, OPEN, SET, FAIL, LOCKOUT.
- Digit buffer:
  - On `key_vld` with `key_val` ≤ 9 and `dcnt` < 6: `buf <= {buf[19:0], key_val}` and `dcnt++`.
  - At `dcnt`=6, further digits are ignored (no wrap).
  - The buffer and `dcnt` clear on every state transition and on `key_cnl`.
- Same-cycle strobe priority: `key_cnl` > `key_ent` > `key_set` > `key_vld`. Only the highest-priority strobe acts.
- IDLE:
  - `key_ent` with `dcnt`=6 and `buf`==`pw_cur`: go to OPEN and clear `fail_cnt`.
  - `key_ent` with `dcnt`=6 and a mismatch: go to FAIL and increment `fail_cnt`.
  - `key_ent` with `dcnt` < 6: no effect.
- FAIL:
  - Lasts exactly one cycle with `err`=1.
  - If `fail_cnt` == MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- OPEN:
  - `unlock`=1; the timer counts OPEN_CYC cycles, then the block returns to IDLE.
  - `key_set` goes to SET.
  - `key_cnl` returns to IDLE immediately.
  - Digits are ignored.
- SET:
  - Digits fill the buffer; there is no timeout.
  - `key_ent` with `dcnt`=6: `pw_we`=1 and `pw_data`=`buf` for one cycle, then IDLE.
  - `key_ent` with `dcnt` < 6: no effect.
  - `key_cnl` returns to IDLE with no write.
- LOCKOUT:
  - `alarm`=1; all keys are ignored, including `key_cnl`.
  - After LOCK_CYC cycles, go to IDLE and clear `fail_cnt`.
- `clr` asserted at any time, including mid-SET, aborts with no write. It forces IDLE and zeroes the buffer, `dcnt`, `fail_cnt` and the timers.

## Timing
- Reset values: `state`=IDLE, `disp`=0, `dcnt`=0, and `pw_we`, `pw_data`, `unlock`, `err`, `alarm` all 0.
- All outputs are registered.
- `key_ent` sampled at cycle N:
  - Correct code: `unlock`=1 during cycles N+1 … N+OPEN_CYC, and 0 at N+OPEN_CYC+1.
  - Wrong code: `err`=1 in cycle N+1.
  - Wrong code that reaches MAX_FAIL: `alarm`=1 in cycles N+2 … N+1+LOCK_CYC.
  - In SET with `dcnt`=6: `pw_we`=1 in cycle N+1.
- `pw_cur` must be stable in the cycle `key_ent` is sampled.
- The `pw_we` to `pw_cur` update latency is the register's concern; the block does not re-read `pw_cur` until the next compare.
- Timer width is `$clog2(max(OPEN_CYC, LOCK_CYC)+1)`. The timer loads on state entry and counts down to 1.
- `fail_cnt` width is `$clog2(MAX_FAIL+1)` and saturates.

## Configuration
- LOCKOUT_EN defined: the `fail_cnt`, LOCKOUT state and `alarm` behave as above.
- LOCKOUT_EN undefined:
  - No `fail_cnt` and no LOCKOUT state; FAIL always returns to IDLE.
  - `alarm` is tied to 0.
  - MAX_FAIL and LOCK_CYC are unused, and the timer is sized by OPEN_CYC only.

## Structure
- Shared package `lock_pkg`:
  - `DIGITS`=6 and `DIGIT_W`=4.
  - State enum `lock_state_t`.
  - The 24-bit code typedef `code_t`.
- One sub-module, `digit_entry_buf`: shift buffer plus `dcnt`, with push, clear and full outputs. The FSM, timer and `fail_cnt` stay in `lock_sequencer`.

## Test plan
- `pw_cur`=0x123456; keys 1,2,3,4,5,6, ent → `unlock`=1 for exactly 8 cycles, then IDLE with `dcnt`=0.
- Keys 1,2,3 then ent → no state change, `dcnt`=3. Keys 4,5,6,7 → `disp`=0x123456 (7 ignored).
- Three wrong codes 000000 → three `err` pulses; after the third, `alarm`=1 for 16 cycles. Keys pressed during lockout are ignored.
- Correct code, `key_set`, keys 9,8,7,6,5,4, ent → single `pw_we` with `pw_data`=0x987654, then IDLE.
- SET with 3 digits entered, then `clr` pulse → IDLE, no `pw_we`, all outputs at reset values. Repeat with `key_cnl` → same result.
- `key_cnl` and `key_ent` in the same cycle with a correct full code → buffer cleared, no unlock. Build with LOCKOUT_EN undefined and enter 5 wrong codes → `alarm` stays 0.
